// File: rtl/gpio_clk_ctrl_if.sv
// Command/config/status bundle between the GPIO control logic (master) and
// the divided-clock run sequencer (slave).
interface gpio_clk_ctrl_if #(
  parameter int width = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [width-1:0] cfg_max_count;
  logic [15:0]      cfg_edges;
  logic             start;
  logic             stop;
  logic             div_clk;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_max_count, cfg_edges, start, stop,
    input  cfg_ready, div_clk, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_max_count, cfg_edges, start, stop,
    output cfg_ready, div_clk, busy, done
  );
endinterface

// File: rtl/gpio_clk_ctrl.sv
// Glitch-free start/stop/burst/retune sequencer owning the divide counter and
// the registered div_clk output.
module gpio_clk_ctrl #(
  parameter int width       = 24,
  parameter int default_max = 10
) (
  input  logic          clk,
  input  logic          rst,
  gpio_clk_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_n;
  logic [width-1:0] count, count_n;
  logic [width-1:0] active_max, active_max_n;
  logic [width-1:0] pending_max, pending_max_n;
  logic             pending, pending_n;
  logic [15:0]      edges_reg, edges_reg_n;
  logic [15:0]      target, target_n;
  logic [15:0]      periods, periods_n;
  logic             div_q, div_n;
  logic             done_q, done_n;
  logic             xfer, hit;

  assign bus.cfg_ready = !pending;
  assign bus.div_clk   = div_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

  assign xfer = bus.cfg_valid && !pending;
  assign hit  = (count == active_max);

  always_comb begin
    state_n       = state;
    count_n       = count;
    active_max_n  = active_max;
    pending_max_n = pending_max;
    pending_n     = pending;
    edges_reg_n   = edges_reg;
    target_n      = target;
    periods_n     = periods;
    div_n         = div_q;
    done_n        = 1'b0;

    if (xfer) begin
      edges_reg_n = bus.cfg_edges;
      if (state == IDLE) begin
        active_max_n = bus.cfg_max_count;
      end else begin
        pending_max_n = bus.cfg_max_count;
        pending_n     = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        count_n = '0;
        div_n   = 1'b0;
        if (bus.start && !bus.stop) begin
          state_n   = RUN;
          target_n  = xfer ? bus.cfg_edges : edges_reg;
          periods_n = '0;
        end
      end
      RUN: begin
        if (bus.stop && !div_q) begin
          // Low phase: safe to park immediately; a held retune is applied now
          // since no further toggle will happen in this run.
          state_n = IDLE;
          count_n = '0;
          done_n  = 1'b1;
          if (pending) begin
            active_max_n = pending_max;
            pending_n    = 1'b0;
          end
        end else if (hit) begin
          count_n = '0;
          div_n   = !div_q;
          if (pending) begin
            active_max_n = pending_max;
            pending_n    = 1'b0;
          end
          if (div_q) begin
            periods_n = periods + 16'd1;
            if (bus.stop || (target != '0 && periods + 16'd1 == target)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end else begin
          count_n = count + 1'b1;
          if (bus.stop) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (hit) begin
          count_n = '0;
          div_n   = 1'b0;
          state_n = IDLE;
          done_n  = 1'b1;
          if (pending) begin
            active_max_n = pending_max;
            pending_n    = 1'b0;
          end
        end else begin
          count_n = count + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      active_max  <= width'(default_max);
      pending_max <= '0;
      pending     <= 1'b0;
      edges_reg   <= '0;
      target      <= '0;
      periods     <= '0;
      div_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      active_max  <= active_max_n;
      pending_max <= pending_max_n;
      pending     <= pending_n;
      edges_reg   <= edges_reg_n;
      target      <= target_n;
      periods     <= periods_n;
      div_q       <= div_n;
      done_q      <= done_n;
    end
  end
endmodule

// File: tb/tb_gpio_clk_ctrl.sv
// Directed bench for gpio_clk_ctrl: burst vector table plus hand sequences
// for free-run, retune, stop/drain, corner commands and async reset.
module tb_gpio_clk_ctrl;
  logic clk, rst;
  int total = 0;
  int bad   = 0;

  gpio_clk_ctrl_if #(.width(24)) bus ();

  gpio_clk_ctrl #(.width(24), .default_max(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [23:0] m;
    logic [15:0] e;
    logic        s;
    logic        p;
    logic        div;
    logic        busy;
    logic        done;
    logic        rdy;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive inputs for one rising edge, then sample 1 time unit after it.
  task automatic tick(input logic v, input logic [23:0] m, input logic [15:0] e,
                      input logic s, input logic p);
    bus.cfg_valid     = v;
    bus.cfg_max_count = m;
    bus.cfg_edges     = e;
    bus.start         = s;
    bus.stop          = p;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
  endtask

  task automatic idle_tick();
    tick(1'b0, 24'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      idle_tick();
      if (bus.done) seen = 1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int trans, last, done_cnt, high_len;
    logic prev;

    bus.cfg_valid = 0; bus.cfg_max_count = 0; bus.cfg_edges = 0;
    bus.start = 0; bus.stop = 0;
    rst = 1'b1;
    #12;
    chk("reset div_clk", {31'd0, bus.div_clk}, 0);
    chk("reset busy", {31'd0, bus.busy}, 0);
    chk("reset done", {31'd0, bus.done}, 0);
    chk("reset cfg_ready", {31'd0, bus.cfg_ready}, 1);
    @(negedge clk);
    rst = 1'b0;

    // Free-run at default_max=10 for 100 cycles.
    tick(1'b0, 24'd0, 16'd0, 1'b1, 1'b0);
    chk("free busy", {31'd0, bus.busy}, 1);
    trans = 0; last = 0; done_cnt = 0; prev = bus.div_clk;
    for (int i = 1; i <= 100; i++) begin
      idle_tick();
      if (bus.done) done_cnt++;
      if (bus.div_clk !== prev) begin
        if (trans == 0) chk("free first rise", i, 11);
        else            chk("free phase len", i - last, 11);
        trans++;
        last = i;
        prev = bus.div_clk;
      end
    end
    chk("free transitions", trans, 9);
    chk("free no done", done_cnt, 0);
    tick(1'b0, 24'd0, 16'd0, 1'b0, 1'b1);
    wait_done("free stop done", 30);
    idle_tick();
    chk("free idle", {31'd0, bus.busy}, 0);

    // Burst: max=1, 3 periods, table-driven.
    tbl[0]  = '{1, 1, 3, 1, 0, 0, 1, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].v, tbl[i].m, tbl[i].e, tbl[i].s, tbl[i].p);
      chk($sformatf("burst div[%0d]", i), {31'd0, bus.div_clk}, {31'd0, tbl[i].div});
      chk($sformatf("burst busy[%0d]", i), {31'd0, bus.busy}, {31'd0, tbl[i].busy});
      chk($sformatf("burst done[%0d]", i), {31'd0, bus.done}, {31'd0, tbl[i].done});
      chk($sformatf("burst rdy[%0d]", i), {31'd0, bus.cfg_ready}, {31'd0, tbl[i].rdy});
    end

    // Retune 4 -> 2 mid high phase; second cfg while pending is refused.
    tick(1'b1, 24'd4, 16'd0, 1'b1, 1'b0);            // E0
    repeat (4) idle_tick();                          // E1..E4
    chk("retune pre rise", {31'd0, bus.div_clk}, 0);
    idle_tick();                                     // E5
    chk("retune rise", {31'd0, bus.div_clk}, 1);
    idle_tick();                                     // E6
    tick(1'b1, 24'd2, 16'd0, 1'b0, 1'b0);            // E7 accepted
    chk("retune pending rdy", {31'd0, bus.cfg_ready}, 0);
    tick(1'b1, 24'd7, 16'd0, 1'b0, 1'b0);            // E8 refused
    chk("retune still pending", {31'd0, bus.cfg_ready}, 0);
    idle_tick();                                     // E9
    chk("retune high held", {31'd0, bus.div_clk}, 1);
    idle_tick();                                     // E10
    chk("retune fall", {31'd0, bus.div_clk}, 0);
    chk("retune rdy back", {31'd0, bus.cfg_ready}, 1);
    idle_tick(); idle_tick();                        // E11, E12
    chk("retune low3", {31'd0, bus.div_clk}, 0);
    idle_tick();                                     // E13
    chk("retune rise3", {31'd0, bus.div_clk}, 1);
    idle_tick(); idle_tick();                        // E14, E15
    chk("retune high3", {31'd0, bus.div_clk}, 1);
    idle_tick();                                     // E16
    chk("retune fall3", {31'd0, bus.div_clk}, 0);
    tick(1'b0, 24'd0, 16'd0, 1'b0, 1'b1);            // E17 stop in low phase
    chk("stop low done", {31'd0, bus.done}, 1);
    chk("stop low busy", {31'd0, bus.busy}, 0);
    chk("stop low div", {31'd0, bus.div_clk}, 0);
    idle_tick();
    chk("stop low done pulse", {31'd0, bus.done}, 0);

    // Stop in high phase with max=5 drains the full 6-cycle high phase.
    tick(1'b1, 24'd5, 16'd0, 1'b1, 1'b0);            // E0
    repeat (6) idle_tick();                          // E1..E6
    chk("drain rise", {31'd0, bus.div_clk}, 1);
    tick(1'b0, 24'd0, 16'd0, 1'b0, 1'b1);            // E7 stop
    chk("drain busy", {31'd0, bus.busy}, 1);
    idle_tick();                                     // E8
    tick(1'b0, 24'd0, 16'd0, 1'b1, 1'b0);            // E9 start ignored
    idle_tick();                                     // E10
    idle_tick();                                     // E11
    chk("drain high end", {31'd0, bus.div_clk}, 1);
    chk("drain no early done", {31'd0, bus.done}, 0);
    idle_tick();                                     // E12
    chk("drain fall", {31'd0, bus.div_clk}, 0);
    chk("drain done", {31'd0, bus.done}, 1);
    chk("drain idle", {31'd0, bus.busy}, 0);
    idle_tick();
    chk("drain stays idle", {31'd0, bus.busy}, 0);

    // start+stop together in IDLE is a no-op.
    tick(1'b0, 24'd0, 16'd0, 1'b1, 1'b1);
    chk("start stop idle", {31'd0, bus.busy}, 0);
    idle_tick();
    chk("start stop idle 2", {31'd0, bus.busy}, 0);

    // Same-cycle cfg max=0 and start: toggles every cycle.
    tick(1'b1, 24'd0, 16'd0, 1'b1, 1'b0);            // E0
    chk("max0 run", {31'd0, bus.busy}, 1);
    chk("max0 e0", {31'd0, bus.div_clk}, 0);
    idle_tick();
    chk("max0 e1", {31'd0, bus.div_clk}, 1);
    idle_tick();
    chk("max0 e2", {31'd0, bus.div_clk}, 0);
    idle_tick();
    chk("max0 e3", {31'd0, bus.div_clk}, 1);
    tick(1'b0, 24'd0, 16'd0, 1'b0, 1'b1);            // stop on falling toggle
    chk("max0 stop done", {31'd0, bus.done}, 1);
    chk("max0 stop div", {31'd0, bus.div_clk}, 0);

    // Async reset mid-burst with a pending retune.
    tick(1'b1, 24'd3, 16'd5, 1'b1, 1'b0);            // E0
    repeat (4) idle_tick();                          // E1..E4
    chk("rst pre div", {31'd0, bus.div_clk}, 1);
    tick(1'b1, 24'd9, 16'd0, 1'b0, 1'b0);
    chk("rst pre pending", {31'd0, bus.cfg_ready}, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst async div", {31'd0, bus.div_clk}, 0);
    chk("rst async busy", {31'd0, bus.busy}, 0);
    chk("rst async rdy", {31'd0, bus.cfg_ready}, 1);
    done_cnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    chk("rst no done", done_cnt, 0);
    rst = 1'b0;
    tick(1'b0, 24'd0, 16'd0, 1'b1, 1'b0);            // E0 with default_max
    high_len = 0;
    for (int i = 1; i <= 11; i++) begin
      idle_tick();
      if (bus.div_clk && high_len == 0) high_len = i;
    end
    chk("rst default rise", high_len, 11);
    tick(1'b0, 24'd0, 16'd0, 1'b0, 1'b1);
    wait_done("rst final done", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
